ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS-subset pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. It computes the result of logic, shift, arithmetic, move and link instructions combinationally. It runs DIV/DIVU on an embedded multi-cycle divider, holding the pipeline through `stallreq_o` until the quotient and remainder are ready.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: number of shift-subtract iterations; equals the data width.

Ports:
- `clk`  in  1: pipeline clock. Divider state updates on the negedge, the same edge as the pipeline registers.
- `rst`  in  1: reset, synchronous, active-high.
- `aluop_i`  in  8: operation code from ID/EX.
- `alusel_i`  in  3: result-class select from ID/EX.
- `reg1_i`, `reg2_i`  in  32: source operands.
- `wd_i`  in  5: destination register address.
- `wreg_i`  in  1: destination write enable.
- `link_address_i`  in  32: return address for link instructions.
- `is_in_delayslot_i`  in  1: instruction occupies a delay slot; passed through unchanged.
- `hi_i`, `lo_i`  in  32: current HI/LO values, already forwarded.
- `wd_o`  out  5: destination register address to EX/MEM.
- `wreg_o`  out  1: write enable to EX/MEM.
- `wdata_o`  out  32: write data to EX/MEM.
- `whilo_o`  out  1: HI/LO write enable.
- `hi_o`, `lo_o`  out  32: HI/LO write data.
- `is_in_delayslot_o`  out  1: delay-slot flag, passed through.
- `stallreq_o`  out  1: stall request to the ctrl unit.

## Operation
Result classes, selected by `alusel_i`:
- LOGIC: OR, AND, XOR, NOR.
- SHIFT: SLL, SRL, SRA. The shift amount is `reg1_i[4:0]`; the shifted value is `reg2_i`.
- ARITH:
  - ADD, ADDU, SUB, SUBU produce a 32-bit wrapped result.
  - SLT is a signed compare; SLTU is an unsigned compare. Either returns 1 or 0.
  - On signed overflow, ADD and SUB force `wreg_o`=0.
- MOVE: MFHI returns `hi_i`; MFLO returns `lo_i`.
- JUMP_BRANCH: returns `link_address_i`.
- NOP or any unknown class: `wdata_o`=0.

HI/LO writes:
- MTHI: `whilo_o`=1, `hi_o`=`reg1_i`, `lo_o`=`lo_i`.
- MTLO: `whilo_o`=1, `hi_o`=`hi_i`, `lo_o`=`reg1_i`.
- DIV/DIVU: `whilo_o`=1 only while the divider is ready, with `hi_o`=remainder and `lo_o`=quotient.
- All other operations: `whilo_o`=0.

Divider:
- `start` = (aluop is DIV or DIVU) and not ready.
- `stallreq_o` = `start`.
- States and transitions:
  - FREE → BY_ZERO when `start` is set and the divisor is 0.
  - FREE → ON when `start` is set and the divisor is nonzero.
  - ON: one restoring shift-subtract iteration per cycle. After `DIV_CYCLES` iterations, move to END.
  - BY_ZERO → END, with the result forced to 0.
  - END: `ready`=1 for exactly one cycle, then unconditionally return to FREE.
- Signed DIV:
  - Operands are converted to magnitudes before iterating.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Example: -7/2 gives q=-3, r=-1.
- The operands are latched on entry to ON, so later input changes do not affect the result.

## Timing
- The non-divide path is fully combinational: zero latency, no stall.
- Nonzero-divisor DIV enters EX:
  - `stallreq_o` rises in the same cycle.
  - There are 1 + 32 + 1 negedges from FREE to END.
  - The result is valid and `stallreq_o` is low in the END cycle.
  - On the next edge, ID/EX loads the next instruction and the divider returns to FREE.
- Divide by zero: FREE→BY_ZERO→END, so 2 edges of stall.
- Back-to-back DIVs: the second DIV finds the divider in FREE and starts normally.
- Reset values:
  - Divider state FREE, `ready`=0, latched result 0.
  - With the NOP that ID/EX presents under reset, all outputs are 0.
- `rst` during ON or END aborts the division: state FREE on the next edge, no HI/LO write.

## Structure
- Opcode, alusel and state encodings belong in the shared `defines.v`: `EXE_*_OP`, `EXE_RES_*`, `DivFree`, `DivOn`, `DivByZero`, `DivEnd`.
- One sub-module, `div`, containing the FSM, the iteration counter, the 65-bit working register and sign fix-up. Its interface is `start`, `signed_div`, `opdata1`, `opdata2`, `result[63:0]`, `ready`.

## Test plan
- ADD 0x7FFFFFFF + 1: `wdata_o`=0x80000000, `wreg_o`=0. Also ADDU of the same operands: `wreg_o`=1, same data.
- SRA with `reg1_i`=4, `reg2_i`=0x80000000 → `wdata_o`=0xF8000000. Also SLTU 1 vs 0xFFFFFFFF → 1; SLT of the same operands → 0.
- DIVU 100/7: `stallreq_o` high for 34 edges, then `lo_o`=14, `hi_o`=2, `whilo_o`=1 for one cycle.
- DIV -7/2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. DIV by 0 → stall for 2 edges, `hi_o`=`lo_o`=0.
- `rst` asserted at iteration 10 of a DIV → state FREE, `whilo_o` never asserted. A following DIVU 9/3 completes normally with q=3, r=0.
- MTHI 0x12345678, then MFHI with `hi_i` forwarded → `wdata_o`=0x12345678. JAL → `wdata_o`=`link_address_i`.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, result classes and
// divider states, plus the two's-complement helpers the divider relies on.
package ex_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [7:0] EXE_JAL_OP  = 8'b0101_0000;
  localparam logic [7:0] EXE_JALR_OP = 8'b0000_1001;

  localparam logic [2:0] EXE_RES_NOP         = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a value that is only treated as signed when en is set.
  function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Multi-cycle restoring divider for DIV/DIVU: works on operand magnitudes,
// then applies the MIPS sign rules (quotient by sign XOR, remainder follows dividend).
module div
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES);

  div_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [64:0]   r_work;
  logic [31:0]   r_divisor;
  logic          r_neg_q;
  logic          r_neg_r;

  logic          w_fits;
  logic [31:0]   w_sub;
  logic [31:0]   w_quo;
  logic [31:0]   w_rem;

  // r_work[64:32] is the partial remainder with the next dividend bit appended;
  // it never exceeds 33 bits, and whenever it fits the difference fits in 32.
  assign w_fits = r_work[64:32] >= {1'b0, r_divisor};
  assign w_sub  = r_work[63:32] - r_divisor;
  assign w_quo  = r_work[31:0];
  assign w_rem  = r_work[64:33];

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      case (r_state)
        DivFree: begin
          if (start) begin
            if (opdata2 == 32'd0) begin
              r_state <= DivByZero;
            end else begin
              r_state   <= DivOn;
              r_cnt     <= '0;
              r_work    <= {32'd0, mag32(opdata1, signed_div), 1'b0};
              r_divisor <= mag32(opdata2, signed_div);
              r_neg_q   <= signed_div & (opdata1[31] ^ opdata2[31]);
              r_neg_r   <= signed_div & opdata1[31];
            end
          end
        end
        DivByZero: begin
          result  <= '0;
          ready   <= 1'b1;
          r_state <= DivEnd;
        end
        DivOn: begin
          if (r_cnt != LAST) begin
            r_work <= w_fits ? {w_sub, r_work[31:0], 1'b1} : {r_work[63:0], 1'b0};
            r_cnt  <= r_cnt + CW'(1);
          end else begin
            result  <= {(r_neg_r ? neg32(w_rem) : w_rem), (r_neg_q ? neg32(w_quo) : w_quo)};
            ready   <= 1'b1;
            r_state <= DivEnd;
          end
        end
        DivEnd: begin
          ready   <= 1'b0;
          r_state <= DivFree;
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU result, HI/LO write data, and the
// stall handshake around the embedded multi-cycle divider.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_address_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        is_in_delayslot_o,
  output logic        stallreq_o
);

  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic [31:0]        w_sum;
  logic [31:0]        w_diff;
  logic               w_add_ov;
  logic               w_sub_ov;
  logic [31:0]        w_logic;
  logic [31:0]        w_shift;
  logic [31:0]        w_arith;
  logic [31:0]        w_move;
  logic               w_is_div;
  logic               w_signed_div;
  logic               w_div_start;
  logic               w_div_ready;
  logic [63:0]        w_div_result;

  assign w_a_s  = reg1_i;
  assign w_b_s  = reg2_i;
  assign w_sum  = reg1_i + reg2_i;
  assign w_diff = reg1_i - reg2_i;

  // Signed overflow: result sign disagrees with what the operand signs imply.
  assign w_add_ov = (reg1_i[31] == reg2_i[31]) && (w_sum[31] != reg1_i[31]);
  assign w_sub_ov = (reg1_i[31] != reg2_i[31]) && (w_diff[31] != reg1_i[31]);

  always_comb begin
    w_logic = '0;
    case (aluop_i)
      EXE_OR_OP:  w_logic = reg1_i | reg2_i;
      EXE_AND_OP: w_logic = reg1_i & reg2_i;
      EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
      default:    w_logic = '0;
    endcase
  end

  always_comb begin
    w_shift = '0;
    case (aluop_i)
      EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: w_shift = w_b_s >>> reg1_i[4:0];
      default:    w_shift = '0;
    endcase
  end

  always_comb begin
    w_arith = '0;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP: w_arith = w_sum;
      EXE_SUB_OP, EXE_SUBU_OP: w_arith = w_diff;
      EXE_SLT_OP:              w_arith = {31'd0, (w_a_s < w_b_s)};
      EXE_SLTU_OP:             w_arith = {31'd0, (reg1_i < reg2_i)};
      default:                 w_arith = '0;
    endcase
  end

  always_comb begin
    w_move = '0;
    case (aluop_i)
      EXE_MFHI_OP: w_move = hi_i;
      EXE_MFLO_OP: w_move = lo_i;
      default:     w_move = '0;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    case (alusel_i)
      EXE_RES_LOGIC:       wdata_o = w_logic;
      EXE_RES_SHIFT:       wdata_o = w_shift;
      EXE_RES_ARITHMETIC:  wdata_o = w_arith;
      EXE_RES_MOVE:        wdata_o = w_move;
      EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
      default:             wdata_o = '0;
    endcase
  end

  assign wd_o              = wd_i;
  assign is_in_delayslot_o = is_in_delayslot_i;
  assign wreg_o            = wreg_i & ~(((aluop_i == EXE_ADD_OP) & w_add_ov) |
                                        ((aluop_i == EXE_SUB_OP) & w_sub_ov));

  // The divider keeps the pipeline frozen until it reports ready for one cycle.
  assign w_is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign w_signed_div = (aluop_i == EXE_DIV_OP);
  assign w_div_start  = w_is_div & ~w_div_ready;
  assign stallreq_o   = w_div_start;

  div #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .signed_div(w_signed_div),
    .opdata1   (reg1_i),
    .opdata2   (reg2_i),
    .result    (w_div_result),
    .ready     (w_div_ready)
  );

  always_comb begin
    whilo_o = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    case (aluop_i)
      EXE_MTHI_OP: begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = lo_i;
      end
      EXE_MTLO_OP: begin
        whilo_o = 1'b1;
        hi_o    = hi_i;
        lo_o    = reg1_i;
      end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        if (w_div_ready) begin
          whilo_o = 1'b1;
          hi_o    = w_div_result[63:32];
          lo_o    = w_div_result[31:0];
        end
      end
      default: begin
        whilo_o = 1'b0;
      end
    endcase
  end

endmodule
